// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronised rx line, oversampled start-bit
// validation, mid-bit data sampling, stop-bit checking and break handling.
// rx_valid and frame_error are registered single-cycle pulses.
module uart_receiver #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Start bit is confirmed half a bit after the falling edge; later samples
    // land one full bit apart, i.e. in the middle of each bit cell.
    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e               state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 rx_meta_q, rx_sync_q;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State, counters, data and pulse registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state logic; nothing but the pulses moves on cycles without a tick.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;

        if (baud_tick) begin
            case (state_q)
                StIdle: begin
                    if (!rx_sync_q) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end

                StStart: begin
                    if (tick_cnt_q == TickMid) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // A high line at mid start bit was only a glitch.
                        state_d    = rx_sync_q ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                StData: begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_cnt_q] = rx_sync_q;
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_d = '0;
                            state_d   = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                StStop: begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        if (rx_sync_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = StBreak;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                StBreak: begin
                    // Wait for the line to recover so a held-low line cannot
                    // be mistaken for a new start bit.
                    if (rx_sync_q) begin
                        state_d = StIdle;
                    end
                end

                default: begin
                    state_d    = StIdle;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        rx_data     = rx_data_q;
        rx_valid    = rx_valid_q;
        frame_error = frame_error_q;
        busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected pulses into a
// queue, an independent monitor pops and checks each pulse as it appears.
module tb_uart_receiver;

    localparam int OS = 16;

    logic       sys_clk;
    logic       reset;
    logic       baud_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    int n_vec;
    int n_err;
    int cyc;
    int tick_div;
    int tick_phase;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         lo;
        int         hi;
    } exp_t;

    exp_t exp_q[$];

    uart_receiver #(
        .DATA_BITS (8),
        .OVERSAMPLE(OS)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_error(frame_error),
        .busy       (busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Baud tick: one cycle in every tick_div, changed on the falling edge.
    initial begin
        baud_tick  = 1'b0;
        tick_phase = 0;
        forever begin
            @(negedge sys_clk);
            tick_phase = tick_phase + 1;
            if (tick_phase >= tick_div) tick_phase = 0;
            baud_tick = (tick_phase == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        n_vec = n_vec + 1;
        if (v < lo || v > hi) begin
            n_err = n_err + 1;
            $display("FAIL %s: got cycle %0d, required %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic int bit_cycles();
        return OS * tick_div;
    endfunction

    // Queue one expected pulse; t0 is the cycle the start bit begins.
    task automatic expect_pulse(input bit is_err, input logic [7:0] d, input int t0);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        e.lo     = t0 + (19 * bit_cycles()) / 2 - tick_div;
        e.hi     = t0 + (19 * bit_cycles()) / 2 + 2 * tick_div + 3;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (bit_cycles()) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (rx_valid || frame_error) begin
                check("pulses_exclusive", {31'd0, rx_valid & frame_error}, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, rx_valid, frame_error}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, frame_error}, {31'd0, e.is_err});
                    check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    check_range("pulse_time", cyc, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        tick_div = 4;
        reset    = 1'b1;
        rx       = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Reset values.
        check("reset_rx_data", {24'd0, rx_data}, 0);
        check("reset_rx_valid", {31'd0, rx_valid}, 0);
        check("reset_frame_error", {31'd0, frame_error}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        repeat (20) @(negedge sys_clk);

        // Single good frame.
        expect_pulse(1'b0, 8'h55, cyc);
        send_frame(8'h55, 1'b1);
        drive_bit(1'b1);
        wait_drain("drain_55", 200);

        // Back-to-back frames, no idle gap.
        expect_pulse(1'b0, 8'hA3, cyc);
        send_frame(8'hA3, 1'b1);
        expect_pulse(1'b0, 8'h0F, cyc);
        send_frame(8'h0F, 1'b1);
        drive_bit(1'b1);
        wait_drain("drain_a3_0f", 200);

        // Short low glitch: rejected at mid start bit.
        rx = 1'b0;
        repeat (16) @(negedge sys_clk);
        rx = 1'b1;
        repeat (200) @(negedge sys_clk);
        check("glitch_busy", {31'd0, busy}, 0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'h0F);

        // Bad stop bit, then line held low: one frame_error, stays busy.
        expect_pulse(1'b1, 8'h0F, cyc);
        send_frame(8'hFF, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        wait_drain("drain_ferr", 50);
        check("break_busy", {31'd0, busy}, 1);
        check("break_rx_data", {24'd0, rx_data}, 32'h0F);
        rx = 1'b1;
        repeat (4 * tick_div + 8) @(negedge sys_clk);
        check("break_release_busy", {31'd0, busy}, 0);
        repeat (100) @(negedge sys_clk);

        // Reset in the middle of data bit 4 of 0x3C (0,0,1,1,1...).
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (bit_cycles() / 2) @(negedge sys_clk);
        check("pre_reset_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("midreset_rx_data", {24'd0, rx_data}, 0);
        check("midreset_rx_valid", {31'd0, rx_valid}, 0);
        check("midreset_frame_error", {31'd0, frame_error}, 0);
        check("midreset_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        repeat (2 * bit_cycles()) @(negedge sys_clk);
        check("post_reset_busy", {31'd0, busy}, 0);
        expect_pulse(1'b0, 8'h81, cyc);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1);
        wait_drain("drain_81", 200);

        // Tick on every cycle: same behaviour, 16 cycles per bit.
        tick_div = 1;
        repeat (40) @(negedge sys_clk);
        expect_pulse(1'b0, 8'h55, cyc);
        send_frame(8'h55, 1'b1);
        drive_bit(1'b1);
        wait_drain("drain_55_fast", 100);
        check("final_busy", {31'd0, busy}, 0);
        check("final_rx_data", {24'd0, rx_data}, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, LSB first.
REQ-002 Parameter OVERSAMPLE, default 16, baud_tick pulses per bit period.
REQ-003 sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 baud_tick  input  1  one-sys_clk enable at OVERSAMPLE x baud rate, from the baud rate generator.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 rx_data  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
REQ-008 rx_valid  output  1  one-sys_clk pulse when rx_data is updated.
REQ-009 frame_error  output  1  one-sys_clk pulse when the stop bit is sampled low.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-012 The tick counter (4 bits at default) and the bit counter SHALL advance only on cycles with baud_tick=1; sys_clk cycles without baud_tick SHALL change no state except the synchronizer and the pulse outputs.
REQ-013 The state machine SHALL have exactly the states IDLE, START, DATA, STOP and BREAK.
REQ-014 IDLE: on baud_tick with rx_sync=0, go to START and set tick counter to 0.
REQ-015 START: on the baud_tick where the tick counter = OVERSAMPLE/2-1 (7), if rx_sync=0 go to DATA with tick and bit counters at 0; if rx_sync=1 go to IDLE (glitch rejected, no outputs).
REQ-016 DATA: on the baud_tick where the tick counter = OVERSAMPLE-1 (15), sample rx_sync into the shift register at bit index = bit counter (LSB first) and reset the tick counter; after bit DATA_BITS-1 go to STOP.
REQ-017 STOP: on the baud_tick where the tick counter = 15, if rx_sync=1, load rx_data from the shift register, pulse rx_valid and go to IDLE.
REQ-018 STOP: on the baud_tick where the tick counter = 15, if rx_sync=0, pulse frame_error, leave rx_data unchanged, assert no rx_valid and go to BREAK.
REQ-019 BREAK: on baud_tick with rx_sync=1, go to IDLE. A line held low SHALL NOT start a new frame.
REQ-020 rx_valid and frame_error SHALL be registered, assert in the sys_clk cycle after the sampling baud_tick, last exactly one cycle, and never assert together.
REQ-021 The tick counter SHALL wrap from OVERSAMPLE-1 to 0 and never exceed it; the bit counter SHALL never exceed DATA_BITS-1.
REQ-022 Back-to-back frames: a start bit detected on the first baud_tick after returning to IDLE SHALL be accepted with no idle gap required beyond the stop bit.
REQ-023 baud_tick asserted on every sys_clk SHALL be legal and produce identical behaviour scaled in time.

Reset
REQ-024 reset SHALL take priority over every other input on the same edge.
REQ-025 On reset: state=IDLE, counters=0, shift register=0, rx_data=0x00, rx_valid=0, frame_error=0, synchronizer flops=1, busy=0.
REQ-026 reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_error pulse; reception resumes at the next falling edge after release.

Verification
REQ-027 Bench drives baud_tick one cycle in every 4 sys_clk (bit = 64 cycles); send 0x55 with a good stop bit -> exactly one rx_valid pulse, rx_data=0x55, frame_error never high.
REQ-028 Send 0xA3 immediately followed by 0x0F -> two rx_valid pulses, rx_data=0xA3 then 0x0F, both sampled at mid-bit (±1 tick).
REQ-029 Pulse rx low for 16 sys_clk (4 ticks) -> return to IDLE, no rx_valid, no frame_error, rx_data unchanged.
REQ-030 Send 0xFF with the stop bit low, then hold rx low for 3 bit times -> one frame_error pulse, rx_data unchanged, busy high until rx returns high, no new frame started.
REQ-031 Assert reset during data bit 4 of 0x3C -> all outputs at reset values, no pulses; a following frame 0x81 is received correctly.
REQ-032 Repeat REQ-027 with baud_tick=1 on every cycle -> rx_data=0x55 with one rx_valid pulse.
